rec_rx_deser: RTL



---
 rtl/rec_rx_pkg.sv | 18 +
 rtl/rec_rx_fifo.sv | 44 ++++
 rtl/rec_rx_deser.sv | 115 +++++++++++
 3 files changed

// File: rtl/rec_rx_pkg.sv
// rec_rx_pkg: slot framing constants, receiver states and word-field packing
// shared by the recording-stream deserializer.
package rec_rx_pkg;

    localparam logic [5:0] FRAME_LEN = 6'd34;
    localparam logic [5:0] HDR_WIN   = 6'd16;
    localparam logic [5:0] B_START   = 6'd0;
    localparam logic [5:0] B_IMP     = 6'd1;
    localparam logic [5:0] B_IDX_MSB = 6'd2;
    localparam logic [5:0] B_DIS     = 6'd7;

    typedef enum logic [1:0] {HUNT, FRAME, SKIP} state_t;

    function automatic logic [6:0] pack_hdr(input logic dis, input logic imp, input logic [4:0] idx);
        return {dis, imp, idx};
    endfunction

endpackage

// File: rtl/rec_rx_fifo.sv
// rec_rx_fifo: show-ahead synchronous FIFO; a pop frees the slot a same-cycle
// push may use, so push-while-full succeeds whenever a pop happens with it.
module rec_rx_fifo #(
    parameter int W     = 23,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr, rd;
    logic         do_push, do_pop;

    assign level   = wr - rd;
    assign empty   = wr == rd;
    assign full    = level == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd[AW-1:0]];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr <= '0;
            rd <= '0;
        end else begin
            wr <= wr + (AW+1)'(do_push);
            rd <= rd + (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rec_rx_deser.sv
// rec_rx_deser: locks onto 34-bit recording slots, decodes header and ADC bits,
// and queues one word per framed slot with header/sequence/overflow flags.
module rec_rx_deser
    import rec_rx_pkg::*;
#(
    parameter int ADC_BITS    = 16,
    parameter int DATA_OFFSET = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          rec_sync_en_i,
    input  logic                          rec_data_i,
    output logic [ADC_BITS+6:0]           word_o,
    output logic                          word_valid_o,
    input  logic                          word_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          locked_o,
    output logic                          hdr_err_o,
    output logic                          seq_err_o,
    output logic                          ovf_o,
    input  logic                          clr_ovf_i
);
    localparam logic [5:0] D0 = 6'(HDR_WIN + 6'(DATA_OFFSET));
    localparam logic [5:0] D1 = 6'(D0 + 6'(ADC_BITS) - 6'd1);

    state_t              state, state_nxt;
    logic [5:0]          cnt, cnt_nxt;
    logic [6:0]          hdr, hdr_nxt;
    logic [ADC_BITS-1:0] data, data_nxt;
    logic [4:0]          exp_idx, exp_nxt;
    logic                first, first_nxt;
    logic                hdr_err_nxt, seq_err_nxt, push, full, empty, overflow;
    logic [ADC_BITS+6:0] push_word;

    assign locked_o     = state != HUNT;
    assign word_valid_o = !empty;
    assign push_word    = {pack_hdr(hdr[0], hdr[B_DIS - B_IMP], hdr[B_DIS - B_IDX_MSB -: 5]), data_nxt};
    assign overflow     = push && full && !(word_ready_i && word_valid_o);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = (cnt == FRAME_LEN - 6'd1) ? '0 : cnt + 6'd1;
        hdr_nxt     = hdr;
        data_nxt    = data;
        exp_nxt     = exp_idx;
        first_nxt   = first;
        hdr_err_nxt = 1'b0;
        seq_err_nxt = 1'b0;
        push        = 1'b0;
        if (!rec_sync_en_i) begin
            state_nxt = HUNT;
            cnt_nxt   = '0;
        end else if (state == HUNT) begin
            first_nxt = 1'b1;
            state_nxt = rec_data_i ? FRAME : HUNT;
            cnt_nxt   = rec_data_i ? B_START + 6'd1 : '0;
        end else if (cnt == B_START) begin
            // An empty slot still advances the expected channel
            state_nxt = rec_data_i ? FRAME : SKIP;
            if (!rec_data_i) exp_nxt = exp_idx + 5'd1;
        end else if (state == FRAME) begin
            if (cnt >= B_IMP && cnt <= B_DIS) hdr_nxt = {hdr[5:0], rec_data_i};
            if (cnt == B_DIS) begin
                seq_err_nxt = !first && (hdr[4:0] != exp_idx);
                exp_nxt     = hdr[4:0] + 5'd1;
                first_nxt   = 1'b0;
            end
            if (cnt > B_DIS && cnt < HDR_WIN && rec_data_i) begin
                hdr_err_nxt = 1'b1;
                state_nxt   = HUNT;
                cnt_nxt     = '0;
            end
            if (cnt >= D0 && cnt <= D1) data_nxt = ADC_BITS'({data, rec_data_i});
            push = cnt == FRAME_LEN - 6'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= HUNT;
            cnt       <= '0;
            hdr       <= '0;
            data      <= '0;
            exp_idx   <= '0;
            first     <= 1'b1;
            hdr_err_o <= 1'b0;
            seq_err_o <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hdr       <= hdr_nxt;
            data      <= data_nxt;
            exp_idx   <= exp_nxt;
            first     <= first_nxt;
            hdr_err_o <= hdr_err_nxt;
            seq_err_o <= seq_err_nxt;
            ovf_o     <= overflow ? 1'b1 : (clr_ovf_i ? 1'b0 : ovf_o);
        end
    end

    rec_rx_fifo #(.W(ADC_BITS + 7), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push      (push),
        .pop       (word_ready_i),
        .din       (push_word),
        .dout      (word_o),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level_o)
    );

endmodule
